fru_seq_pla: RTL

- Registered, reconfigurable successor to the combinational segmented FRU PLA.
- Each of OUTPUT_SIZE channels selects SEGMENT_SIZE trigger bits from Qin through independent per-bit muxes. The selected bits index a 2**SEGMENT_SIZE minterm OR-mask.
- Each channel then applies a temporal mode (level, sticky, stretch, edge) before driving FruSelect.
- Configuration goes through shadow registers with a valid/ready write port and an atomic commit. The FRU sees no partially applied config.

---
 rtl/fru_seq_pla.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/fru_seq_pla.sv
// fru_seq_pla: registered, reconfigurable segmented FRU PLA.
// Each channel picks SEGMENT_SIZE trigger bits from Qin through independent
// muxes. Those bits index a minterm OR-mask, and the result passes through a
// per-channel temporal mode (level / sticky / stretch / edge) before it drives
// FruSelect. Configuration is written into shadow registers and applied to
// every channel at once by a single-cycle COMMIT state.
module fru_seq_pla #(
  parameter  int INPUT_SIZE   = 8,
  parameter  int OUTPUT_SIZE  = 4,
  parameter  int SEGMENT_SIZE = 2,
  parameter  int HOLD_W       = 4,
  localparam int SW           = $clog2(INPUT_SIZE),
  localparam int IW           = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [INPUT_SIZE-1:0]        Qin,
  input  logic                         CfgValid,
  output logic                         CfgReady,
  input  logic [IW-1:0]                CfgIdx,
  input  logic [SEGMENT_SIZE*SW-1:0]   CfgMux,
  input  logic [2**SEGMENT_SIZE-1:0]   CfgMinterm,
  input  logic [1:0]                   CfgMode,
  input  logic [HOLD_W-1:0]            CfgHold,
  input  logic                         CfgCommit,
  input  logic [OUTPUT_SIZE-1:0]       ClearSticky,
  output logic [OUTPUT_SIZE-1:0]       FruSelect,
  output logic                         CfgPending
);

  localparam int MUX_W = SEGMENT_SIZE * SW;
  localparam int MT_W  = 2 ** SEGMENT_SIZE;
  localparam int QP_W  = 2 ** SW;

  // Largest legal channel index + 1, sized one bit wider than CfgIdx.
  localparam logic [IW:0] OUT_LIM = OUTPUT_SIZE[IW:0];

  typedef enum logic [1:0] {
    MODE_LEVEL   = 2'd0,
    MODE_STICKY  = 2'd1,
    MODE_STRETCH = 2'd2,
    MODE_EDGE    = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_COMMIT = 1'b1
  } state_e;

  typedef struct packed {
    logic [MUX_W-1:0]  mux;
    logic [MT_W-1:0]   minterm;
    logic [1:0]        mode;
    logic [HOLD_W-1:0] hold;
  } cfg_t;

  state_e                 state_q, state_d;
  cfg_t                   shadow_q [OUTPUT_SIZE];
  cfg_t                   shadow_d [OUTPUT_SIZE];
  cfg_t                   active_q [OUTPUT_SIZE];
  cfg_t                   active_d [OUTPUT_SIZE];
  logic                   pending_q, pending_d;
  logic [OUTPUT_SIZE-1:0] sel_q, sel_d;
  logic [OUTPUT_SIZE-1:0] prev_q, prev_d;
  logic [HOLD_W-1:0]      cnt_q [OUTPUT_SIZE];
  logic [HOLD_W-1:0]      cnt_d [OUTPUT_SIZE];

  logic [QP_W-1:0]         qpad;
  logic [SEGMENT_SIZE-1:0] seg_w [OUTPUT_SIZE];
  logic [OUTPUT_SIZE-1:0]  p_w;
  logic                    wr_fire;
  logic                    idx_ok;

  assign CfgReady   = (state_q == ST_IDLE);
  assign CfgPending = pending_q;
  assign FruSelect  = sel_q;
  assign wr_fire    = CfgValid & CfgReady;
  assign idx_ok     = ({1'b0, CfgIdx} < OUT_LIM);

  // PLA: Qin is zero-padded to 2**SW bits so mux selects beyond INPUT_SIZE read 0.
  always_comb begin
    qpad = '0;
    qpad[INPUT_SIZE-1:0] = Qin;
    p_w = '0;
    for (int unsigned i = 0; i < OUTPUT_SIZE; i++) begin
      seg_w[i] = '0;
      for (int unsigned k = 0; k < SEGMENT_SIZE; k++) begin
        seg_w[i][k] = qpad[active_q[i].mux[k*SW +: SW]];
      end
      p_w[i] = active_q[i].minterm[seg_w[i]];
    end
  end

  // Next-state: config FSM, shadow writes, commit copy and per-channel modes.
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    sel_d     = sel_q;
    prev_d    = prev_q;
    cnt_d     = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (wr_fire && idx_ok) begin
          for (int unsigned i = 0; i < OUTPUT_SIZE; i++) begin
            if (32'(CfgIdx) == i) begin
              shadow_d[i] = {CfgMux, CfgMinterm, CfgMode, CfgHold};
            end
          end
          pending_d = 1'b1;
        end
        if (CfgCommit) begin
          state_d = ST_COMMIT;
        end
        for (int unsigned i = 0; i < OUTPUT_SIZE; i++) begin
          case (mode_e'(active_q[i].mode))
            MODE_LEVEL: begin
              sel_d[i] = p_w[i];
            end
            MODE_STICKY: begin
              sel_d[i] = ClearSticky[i] ? 1'b0 : (sel_q[i] | p_w[i]);
            end
            MODE_STRETCH: begin
              if (p_w[i]) begin
                sel_d[i] = 1'b1;
                cnt_d[i] = active_q[i].hold;
              end else if (cnt_q[i] != '0) begin
                sel_d[i] = 1'b1;
                cnt_d[i] = cnt_q[i] - HOLD_W'(1);
              end else begin
                sel_d[i] = 1'b0;
              end
            end
            MODE_EDGE: begin
              sel_d[i]  = p_w[i] & ~prev_q[i];
              prev_d[i] = p_w[i];
            end
            default: sel_d[i] = 1'b0;
          endcase
        end
      end
      ST_COMMIT: begin
        // Shadow already holds any write accepted alongside the commit request.
        active_d  = shadow_q;
        sel_d     = '0;
        prev_d    = '0;
        for (int unsigned i = 0; i < OUTPUT_SIZE; i++) begin
          cnt_d[i] = '0;
        end
        pending_d = 1'b0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      sel_q     <= '0;
      prev_q    <= '0;
      for (int unsigned i = 0; i < OUTPUT_SIZE; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      sel_q     <= sel_d;
      prev_q    <= prev_d;
      for (int unsigned i = 0; i < OUTPUT_SIZE; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
    end
  end

endmodule
